// File: rtl/instr_realign.sv
// Fetch-block realigner: splits a 32-bit fetch block into up to two RVC/RVI instructions
// and carries the lower half of an RVI instruction that straddles into the next block.
module instr_realign #(
    parameter int unsigned VLEN = 39
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                valid_i,
    input  logic [VLEN-1:0]     address_i,
    input  logic [31:0]         data_i,
    output logic                serving_unaligned_o,
    output logic [1:0]          valid_o,
    output logic [2*VLEN-1:0]   addr_o,
    output logic [63:0]         instr_o
);

    localparam logic [VLEN-1:0] HALF_STEP = {{(VLEN-2){1'b0}}, 2'b10};

    function automatic logic is_rvc(input logic [15:0] half);
        return (half[1:0] != 2'b11);
    endfunction

    logic               unaligned_r;
    logic [15:0]        unaligned_instr_r;
    logic [VLEN-1:0]    unaligned_addr_r;

    logic               unaligned_d_s;
    logic [15:0]        unaligned_instr_d_s;
    logic [VLEN-1:0]    unaligned_addr_d_s;

    logic [1:0]         valid_s;
    logic [31:0]        instr0_s;
    logic [31:0]        instr1_s;
    logic [VLEN-1:0]    addr0_s;
    logic [VLEN-1:0]    addr1_s;
    logic [VLEN-1:0]    addr_plus2_s;
    logic [15:0]        lower_s;
    logic [15:0]        upper_s;

    assign lower_s      = data_i[15:0];
    assign upper_s      = data_i[31:16];
    assign addr_plus2_s = address_i + HALF_STEP;

    // Slot decode and next-state selection for the held straddling half.
    always_comb begin
        valid_s             = 2'b00;
        instr0_s            = 32'h0000_0000;
        instr1_s            = 32'h0000_0000;
        addr0_s             = address_i;
        addr1_s             = addr_plus2_s;
        unaligned_d_s       = unaligned_r;
        unaligned_instr_d_s = unaligned_instr_r;
        unaligned_addr_d_s  = unaligned_addr_r;

        if (flush_i) begin
            unaligned_d_s = 1'b0;
        end else if (valid_i) begin
            case ({unaligned_r, address_i[1]})
                2'b00: begin
                    if (!is_rvc(lower_s)) begin
                        instr0_s = data_i;
                        valid_s  = 2'b01;
                    end else begin
                        instr0_s = {16'h0000, lower_s};
                        if (is_rvc(upper_s)) begin
                            instr1_s = {16'h0000, upper_s};
                            valid_s  = 2'b11;
                        end else begin
                            unaligned_instr_d_s = upper_s;
                            unaligned_addr_d_s  = addr_plus2_s;
                            unaligned_d_s       = 1'b1;
                            valid_s             = 2'b01;
                        end
                    end
                end
                2'b01: begin
                    // Redirect into the upper half: the lower half is not part of the stream.
                    if (is_rvc(upper_s)) begin
                        instr0_s = {16'h0000, upper_s};
                        valid_s  = 2'b01;
                    end else begin
                        unaligned_instr_d_s = upper_s;
                        unaligned_addr_d_s  = address_i;
                        unaligned_d_s       = 1'b1;
                        valid_s             = 2'b00;
                    end
                end
                2'b10, 2'b11: begin
                    instr0_s = {lower_s, unaligned_instr_r};
                    addr0_s  = unaligned_addr_r;
                    if (is_rvc(upper_s)) begin
                        instr1_s      = {16'h0000, upper_s};
                        unaligned_d_s = 1'b0;
                        valid_s       = 2'b11;
                    end else begin
                        unaligned_instr_d_s = upper_s;
                        unaligned_addr_d_s  = addr_plus2_s;
                        unaligned_d_s       = 1'b1;
                        valid_s             = 2'b01;
                    end
                end
                default: begin
                    valid_s = 2'b00;
                end
            endcase
        end else begin
            unaligned_d_s = unaligned_r;
        end
    end

    // Output gating: nothing is presented while reset is asserted.
    always_comb begin
        if (rst_ni) begin
            valid_o = valid_s;
        end else begin
            valid_o = 2'b00;
        end
    end

    assign instr_o             = {instr1_s, instr0_s};
    assign addr_o              = {addr1_s, addr0_s};
    assign serving_unaligned_o = unaligned_r;

    // Held-half state register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            unaligned_r       <= 1'b0;
            unaligned_instr_r <= 16'h0000;
            unaligned_addr_r  <= {VLEN{1'b0}};
        end else begin
            unaligned_r       <= unaligned_d_s;
            unaligned_instr_r <= unaligned_instr_d_s;
            unaligned_addr_r  <= unaligned_addr_d_s;
        end
    end

endmodule

// File: tb/tb_instr_realign.sv
// Self-checking bench for instr_realign: directed vector table plus randomized
// stimulus checked against a halfword-stream reference model.
module tb_instr_realign;

    localparam int unsigned VLEN = 39;

    logic                clk_s;
    logic                rst_n_s;
    logic                flush_s;
    logic                valid_s;
    logic [VLEN-1:0]     address_s;
    logic [31:0]         data_s;
    logic                serving_s;
    logic [1:0]          valid_o_s;
    logic [2*VLEN-1:0]   addr_o_s;
    logic [63:0]         instr_o_s;

    int n_checks;
    int n_fail;

    instr_realign #(.VLEN(VLEN)) dut (
        .clk_i               (clk_s),
        .rst_ni              (rst_n_s),
        .flush_i             (flush_s),
        .valid_i             (valid_s),
        .address_i           (address_s),
        .data_i              (data_s),
        .serving_unaligned_o (serving_s),
        .valid_o             (valid_o_s),
        .addr_o              (addr_o_s),
        .instr_o             (instr_o_s)
    );

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    typedef struct {
        logic            rst_n;
        logic            flush;
        logic            valid;
        logic [VLEN-1:0] addr;
        logic [31:0]     data;
        logic            exp_serving;
        logic [1:0]      exp_valid;
        logic [31:0]     exp_i0;
        logic [VLEN-1:0] exp_a0;
        logic [31:0]     exp_i1;
        logic [VLEN-1:0] exp_a1;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst_n, input logic flush, input logic valid,
                                input logic [63:0] addr, input logic [31:0] data,
                                input logic es, input logic [1:0] ev,
                                input logic [31:0] i0, input logic [63:0] a0,
                                input logic [31:0] i1, input logic [63:0] a1);
        vec_t v;
        v.rst_n = rst_n; v.flush = flush; v.valid = valid;
        v.addr = addr[VLEN-1:0]; v.data = data;
        v.exp_serving = es; v.exp_valid = ev;
        v.exp_i0 = i0; v.exp_a0 = a0[VLEN-1:0];
        v.exp_i1 = i1; v.exp_a1 = a1[VLEN-1:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic es, input logic [1:0] ev,
                                 input logic [31:0] i0, input logic [VLEN-1:0] a0,
                                 input logic [31:0] i1, input logic [VLEN-1:0] a1);
        chk({tag, " serving"}, 64'(serving_s), 64'(es));
        chk({tag, " valid"}, 64'(valid_o_s), 64'(ev));
        if (ev[0]) begin
            chk({tag, " instr0"}, 64'(instr_o_s[31:0]), 64'(i0));
            chk({tag, " addr0"}, 64'(addr_o_s[VLEN-1:0]), 64'(a0));
        end
        if (ev[1]) begin
            chk({tag, " instr1"}, 64'(instr_o_s[63:32]), 64'(i1));
            chk({tag, " addr1"}, 64'(addr_o_s[2*VLEN-1:VLEN]), 64'(a1));
        end
    endtask

    // Reference model: pending straddling half as an explicit halfword in a stream
    logic            m_pend;
    logic [15:0]     m_pend_h;
    logic [VLEN-1:0] m_pend_a;

    task automatic model_eval(input logic rst_n, input logic flush, input logic valid,
                              input logic [VLEN-1:0] addr, input logic [31:0] data,
                              output logic [1:0] ev, output logic [31:0] i0, output logic [VLEN-1:0] a0,
                              output logic [31:0] i1, output logic [VLEN-1:0] a1,
                              output logic np, output logic [15:0] nh, output logic [VLEN-1:0] na);
        logic [15:0]     h[3];
        logic [VLEN-1:0] ha[3];
        logic [31:0]     oi[2];
        logic [VLEN-1:0] oa[2];
        int n = 0;
        int k = 0;
        int i = 0;
        logic [VLEN-1:0] two;
        two = VLEN'(2);
        np = m_pend; nh = m_pend_h; na = m_pend_a;
        oi[0] = 32'h0; oi[1] = 32'h0; oa[0] = '0; oa[1] = '0;
        if (m_pend) begin h[n] = m_pend_h; ha[n] = m_pend_a; n++; end
        if (m_pend || !addr[1]) begin h[n] = data[15:0]; ha[n] = addr; n++; end
        h[n] = data[31:16];
        ha[n] = m_pend ? addr + two : (addr[1] ? addr : addr + two);
        n++;
        np = 1'b0;
        while (i < n) begin
            if (h[i][1:0] != 2'b11) begin
                oi[k] = {16'h0, h[i]}; oa[k] = ha[i]; k++; i++;
            end else if (i + 1 < n) begin
                oi[k] = {h[i+1], h[i]}; oa[k] = ha[i]; k++; i += 2;
            end else begin
                np = 1'b1; nh = h[i]; na = ha[i]; i++;
            end
        end
        ev = (k == 0) ? 2'b00 : ((k == 1) ? 2'b01 : 2'b11);
        i0 = oi[0]; a0 = oa[0]; i1 = oi[1]; a1 = oa[1];
        if (!rst_n) begin
            ev = 2'b00; np = 1'b0;
        end else if (flush) begin
            ev = 2'b00; np = 1'b0;
        end else if (!valid) begin
            ev = 2'b00; np = m_pend; nh = m_pend_h; na = m_pend_a;
        end
    endtask

    function automatic logic [15:0] rand_half();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 0) h[1:0] = 2'b11;
        else if (h[1:0] == 2'b11) h[1:0] = 2'(($urandom_range(0, 2)));
        return h;
    endfunction

    initial begin
        logic [1:0]      ev;
        logic [31:0]     i0, i1;
        logic [VLEN-1:0] a0, a1, na, cur;
        logic            np;
        logic [15:0]     nh;
        vec_t            v;

        n_checks = 0;
        n_fail   = 0;
        rst_n_s = 1'b0; flush_s = 1'b0; valid_s = 1'b0; address_s = '0; data_s = 32'h0;
        repeat (2) @(posedge clk_s);

        vq.push_back(mk(1'b0, 1'b0, 1'b1, 64'h1000, 32'h00014501, 1'b0, 2'b00, 32'h0, 64'h0, 32'h0, 64'h0));
        vq.push_back(mk(1'b1, 1'b0, 1'b1, 64'h80000000, 32'h00000013, 1'b0, 2'b01, 32'h00000013, 64'h80000000, 32'h0, 64'h0));
        vq.push_back(mk(1'b1, 1'b0, 1'b1, 64'h1000, 32'h00014501, 1'b0, 2'b11, 32'h00004501, 64'h1000, 32'h00000001, 64'h1002));
        vq.push_back(mk(1'b1, 1'b0, 1'b1, 64'h1000, 32'h05134501, 1'b0, 2'b01, 32'h00004501, 64'h1000, 32'h0, 64'h0));
        vq.push_back(mk(1'b1, 1'b0, 1'b1, 64'h1004, 32'h00010000, 1'b1, 2'b11, 32'h00000513, 64'h1002, 32'h00000001, 64'h1006));
        vq.push_back(mk(1'b1, 1'b0, 1'b1, 64'h2002, 32'h0001FFFF, 1'b0, 2'b01, 32'h00000001, 64'h2002, 32'h0, 64'h0));
        vq.push_back(mk(1'b1, 1'b0, 1'b1, 64'h2002, 32'h0513FFFF, 1'b0, 2'b00, 32'h0, 64'h0, 32'h0, 64'h0));
        vq.push_back(mk(1'b1, 1'b0, 1'b1, 64'h2004, 32'h00010000, 1'b1, 2'b11, 32'h00000513, 64'h2002, 32'h00000001, 64'h2006));
        vq.push_back(mk(1'b1, 1'b0, 1'b1, 64'h1000, 32'h05134501, 1'b0, 2'b01, 32'h00004501, 64'h1000, 32'h0, 64'h0));
        vq.push_back(mk(1'b1, 1'b1, 1'b1, 64'h1004, 32'h00010000, 1'b1, 2'b00, 32'h0, 64'h0, 32'h0, 64'h0));
        vq.push_back(mk(1'b1, 1'b0, 1'b1, 64'h3000, 32'h00000013, 1'b0, 2'b01, 32'h00000013, 64'h3000, 32'h0, 64'h0));
        vq.push_back(mk(1'b1, 1'b0, 1'b1, 64'h1000, 32'h05134501, 1'b0, 2'b01, 32'h00004501, 64'h1000, 32'h0, 64'h0));
        vq.push_back(mk(1'b0, 1'b0, 1'b1, 64'h1004, 32'h00010000, 1'b1, 2'b00, 32'h0, 64'h0, 32'h0, 64'h0));
        vq.push_back(mk(1'b1, 1'b0, 1'b1, 64'h3000, 32'h00000013, 1'b0, 2'b01, 32'h00000013, 64'h3000, 32'h0, 64'h0));
        vq.push_back(mk(1'b1, 1'b0, 1'b1, 64'h1000, 32'h05134501, 1'b0, 2'b01, 32'h00004501, 64'h1000, 32'h0, 64'h0));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 64'h1004, 32'h00010000, 1'b1, 2'b00, 32'h0, 64'h0, 32'h0, 64'h0));
        vq.push_back(mk(1'b1, 1'b0, 1'b1, 64'h1004, 32'h00010000, 1'b1, 2'b11, 32'h00000513, 64'h1002, 32'h00000001, 64'h1006));
        vq.push_back(mk(1'b1, 1'b0, 1'b1, 64'h7FFFFFFFFC, 32'h00010001, 1'b0, 2'b11, 32'h00000001, 64'h7FFFFFFFFC, 32'h00000001, 64'h7FFFFFFFFE));
        vq.push_back(mk(1'b1, 1'b0, 1'b1, 64'h7FFFFFFFFC, 32'h05130001, 1'b0, 2'b01, 32'h00000001, 64'h7FFFFFFFFC, 32'h0, 64'h0));
        vq.push_back(mk(1'b1, 1'b0, 1'b1, 64'h0, 32'h00010000, 1'b1, 2'b11, 32'h00000513, 64'h7FFFFFFFFE, 32'h00000001, 64'h2));
        vq.push_back(mk(1'b1, 1'b0, 1'b1, 64'h4000, 32'h00000013, 1'b0, 2'b01, 32'h00000013, 64'h4000, 32'h0, 64'h0));

        for (int vi = 0; vi < vq.size(); vi++) begin
            v = vq[vi];
            @(negedge clk_s);
            rst_n_s = v.rst_n; flush_s = v.flush; valid_s = v.valid;
            address_s = v.addr; data_s = v.data;
            #1;
            check_outputs($sformatf("vec%0d", vi), v.exp_serving, v.exp_valid,
                          v.exp_i0, v.exp_a0, v.exp_i1, v.exp_a1);
            @(posedge clk_s);
        end

        // Randomized run against the reference model, starting from reset
        @(negedge clk_s);
        rst_n_s = 1'b0; valid_s = 1'b0; flush_s = 1'b0;
        @(posedge clk_s);
        m_pend = 1'b0; m_pend_h = 16'h0; m_pend_a = '0;
        cur = VLEN'(64'h7FFFFFFF00);
        for (int it = 0; it < 3000; it++) begin
            @(negedge clk_s);
            rst_n_s = ($urandom_range(0, 99) != 0);
            flush_s = ($urandom_range(0, 19) == 0);
            valid_s = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 15) == 0) begin
                cur = VLEN'({$urandom, $urandom});
                cur[0] = 1'b0;
            end
            address_s = cur;
            data_s = {rand_half(), rand_half()};
            model_eval(rst_n_s, flush_s, valid_s, address_s, data_s, ev, i0, a0, i1, a1, np, nh, na);
            #1;
            check_outputs("rand", m_pend, ev, i0, a0, i1, a1);
            @(posedge clk_s);
            m_pend = np; m_pend_h = nh; m_pend_a = na;
            if (valid_s && !flush_s && rst_n_s) begin
                cur = {address_s[VLEN-1:2], 2'b00} + VLEN'(4);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
